// File: rtl/event_debouncer_pkg.sv
// Shared types and constants for the event debouncer: FSM state encoding,
// glitch counter width/saturation value and the saturating increment helper.
package event_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // debounced level 0
    DB_HI = 2'd1,  // qualifying a rise
    HIGH  = 2'd2,  // debounced level 1
    DB_LO = 2'd3   // qualifying a fall
  } db_state_e;

  localparam int                    GLITCH_W   = 8;
  localparam logic [GLITCH_W-1:0]   GLITCH_MAX = 8'd255;
  localparam int                    CNT_W      = 8;

  // Increment that sticks at GLITCH_MAX instead of wrapping to zero.
  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    if (v == GLITCH_MAX) begin
      sat_inc = GLITCH_MAX;
    end else begin
      sat_inc = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/event_debouncer_input_synchronizer.sv
// Multi-flop synchronizer bringing the asynchronous event source into the
// clk domain. Only the last stage is meant to be used downstream.
module input_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift the raw input through the chain; synchronous reset clears every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{1'b0}};
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/event_debouncer.sv
// Debouncer for a bouncy button/sensor: synchronizes raw_in, qualifies level
// changes after DB_CYCLES stable samples, emits a one-cycle registered pulse
// on each qualified rise and counts rejected transitions (saturating).
module event_debouncer
  import event_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                raw_in,
  output logic                en_out,
  output logic                level_out,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // Last count value before the level change is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic                s_sync;
  db_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                fire_q, fire_d;
  logic                en_q, en_d;
  logic                level_q, level_d;

  input_synchronizer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (raw_in),
    .sync_o  (s_sync)
  );

  // State, counters and output registers; reset aborts any qualification quietly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      glitch_q <= 8'd0;
      fire_q   <= 1'b0;
      en_q     <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
      fire_q   <= fire_d;
      en_q     <= en_d;
      level_q  <= level_d;
    end
  end

  // Next-state logic: count stable samples, reject early reversals as glitches.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = glitch_q;
    fire_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_sync) begin
          state_d = DB_HI;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      DB_HI: begin
        if (s_sync) begin
          if (cnt_q >= CNT_LAST) begin
            state_d = HIGH;
            cnt_d   = 8'd0;
            fire_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 8'd1;
          end
        end else begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          glitch_d = sat_inc(glitch_q);
        end
      end
      HIGH: begin
        if (!s_sync) begin
          state_d = DB_LO;
          cnt_d   = 8'd1;
        end else begin
          cnt_d   = 8'd0;
        end
      end
      DB_LO: begin
        if (!s_sync) begin
          if (cnt_q >= CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
          end
        end else begin
          state_d  = HIGH;
          cnt_d    = 8'd0;
          glitch_d = sat_inc(glitch_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // The pulse lands one cycle after the rise is qualified, straight from a flop.
    en_d    = fire_q;
    level_d = (state_d == HIGH) || (state_d == DB_LO);
  end

  assign en_out     = en_q;
  assign level_out  = level_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_event_debouncer.sv
// Self-checking bench for event_debouncer: directed scenarios plus random
// bursts, compared against a run-length reference model of the debouncer.
module tb_event_debouncer;

  localparam int SYNC = 2;
  localparam int DB   = 16;
  localparam int LAT  = SYNC + DB;

  logic       clk;
  logic       rst_n;
  logic       raw_in;
  logic       en_out;
  logic       level_out;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_hist[$];
  bit m_level;
  int m_run;
  int m_glitch;
  bit m_pend;
  bit m_en;

  // Downstream counter driven by en_out as its enable
  int dn_count;

  event_debouncer #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (raw_in),
    .en_out     (en_out),
    .level_out  (level_out),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: delayed sample, run length of samples disagreeing with the level.
  always @(posedge clk) begin : model_blk
    bit s;
    if (!rst_n) begin
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_level  = 1'b0;
      m_run    = 0;
      m_glitch = 0;
      m_pend   = 1'b0;
      m_en     = 1'b0;
    end else begin
      s = m_hist.pop_front();
      m_hist.push_back(raw_in);
      m_en   = m_pend;
      m_pend = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = s;
          m_run   = 0;
          if (s) m_pend = 1'b1;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
  end

  // Downstream event counter enabled by en_out.
  always @(posedge clk) begin
    if (!rst_n) dn_count <= 0;
    else if (en_out) dn_count <= dn_count + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    raw_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    raw_in = 1'($urandom_range(0, 1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (en_out !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", en_out); end
    checks++;
    if (level_out !== 1'b0) begin errors++; $display("FAIL reset_level: got %0b want 0", level_out); end
    checks++;
    if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL reset_glitch: got %0d want 0", glitch_cnt); end
    raw_in = 1'b0;
    rst_n  = 1'b1;
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int first_k = -1;
    do_reset();
    repeat (4) @(negedge clk);
    raw_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (en_out === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      checks++;
      if (en_out !== m_en || level_out !== m_level) begin
        errors++;
        $display("FAIL press_cycle%0d: en/level got %0b/%0b want %0b/%0b", k, en_out, level_out, m_en, m_level);
      end
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL press_pulses: got %0d want 1", pulses); end
    checks++;
    if (first_k != LAT) begin errors++; $display("FAIL press_latency: got %0d want %0d", first_k, LAT); end
    checks++;
    if (level_out !== 1'b1) begin errors++; $display("FAIL press_level: got %0b want 1", level_out); end
    checks++;
    if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL press_glitch: got %0d want 0", glitch_cnt); end
  endtask

  task automatic test_release();
    int pulses = 0;
    int low_k = -1;
    raw_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (en_out === 1'b1) pulses++;
      if (level_out === 1'b0 && low_k < 0) low_k = k;
      checks++;
      if (level_out !== m_level) begin
        errors++;
        $display("FAIL release_cycle%0d: level got %0b want %0b", k, level_out, m_level);
      end
    end
    checks++;
    if (low_k != LAT - 1) begin errors++; $display("FAIL release_latency: got %0d want %0d", low_k, LAT - 1); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL release_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (en_out === 1'b1) pulses++;
      checks++;
      if (en_out !== m_en || level_out !== m_level || glitch_cnt !== 8'(m_glitch)) begin
        errors++;
        $display("FAIL bounce_cycle%0d: en/level/glitch got %0b/%0b/%0d want %0b/%0b/%0d",
                 k, en_out, level_out, glitch_cnt, m_en, m_level, m_glitch);
      end
      raw_in = (k >= 30) ? 1'b1 : 1'(((k / 3) % 2) == 0);
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL bounce_pulses: got %0d want 1", pulses); end
    checks++;
    if (glitch_cnt == 8'd0) begin errors++; $display("FAIL bounce_glitch: got %0d want >=1", glitch_cnt); end
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int low_len;
    do_reset();
    for (int b = 0; b < 300; b++) begin
      low_len = $urandom_range(3, 6);
      for (int c = 0; c < 2 + low_len; c++) begin
        @(negedge clk);
        if (en_out === 1'b1) pulses++;
        checks++;
        if (glitch_cnt !== 8'(m_glitch) || en_out !== m_en) begin
          errors++;
          $display("FAIL sat_blip%0d: en/glitch got %0b/%0d want %0b/%0d", b, en_out, glitch_cnt, m_en, m_glitch);
        end
        raw_in = 1'(c < 2);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (glitch_cnt !== 8'd255) begin errors++; $display("FAIL sat_value: got %0d want 255", glitch_cnt); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL sat_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int first_k = -1;
    do_reset();
    raw_in = 1'b1;
    // After edge 9 the qualification counter holds 8.
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (en_out !== 1'b0 || level_out !== 1'b0 || glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs: en/level/glitch got %0b/%0b/%0d want 0/0/0", en_out, level_out, glitch_cnt);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (en_out === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    checks++;
    if (first_k != LAT) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", first_k, LAT); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL midreset_pulses: got %0d want 1", pulses); end
    checks++;
    if (glitch_cnt !== 8'd0) begin errors++; $display("FAIL midreset_glitch: got %0d want 0", glitch_cnt); end
  endtask

  task automatic test_random();
    int hold;
    bit v;
    do_reset();
    for (int b = 0; b < 80; b++) begin
      v = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 2) == 0) ? $urandom_range(DB, 2 * DB + 4) : $urandom_range(1, DB + 2);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        checks++;
        if (en_out !== m_en || level_out !== m_level || glitch_cnt !== 8'(m_glitch)) begin
          errors++;
          $display("FAIL random_burst%0d: en/level/glitch got %0b/%0b/%0d want %0b/%0b/%0d",
                   b, en_out, level_out, glitch_cnt, m_en, m_level, m_glitch);
        end
        raw_in = v;
      end
    end
  endtask

  task automatic test_integration();
    do_reset();
    for (int p = 0; p < 5; p++) begin
      raw_in = 1'b1;
      repeat (30) @(negedge clk);
      raw_in = 1'b0;
      repeat (30) @(negedge clk);
    end
    checks++;
    if (dn_count != 5) begin errors++; $display("FAIL integration_count: got %0d want 5", dn_count); end
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = 1'b0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_saturation();
    test_reset_mid();
    test_random();
    test_integration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
